// File: rtl/vga_pkg.sv
// Shared VGA constants and types used by the sprite overlay stage and its helpers.
package vga_pkg;

  localparam int H_ACTIVE_640 = 640;
  localparam int V_ACTIVE_480 = 480;
  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic {
    DIR_INC,
    DIR_DEC
  } dir_t;

endpackage

// File: rtl/vga_sprite_overlay_if.sv
// Video stream bundle: timing/background in from the upstream generators, final pixels out to the pins.
interface vga_sprite_overlay_if;

  logic [9:0] hcount_in;
  logic [9:0] vcount_in;
  logic       vga_active_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [3:0] bg_r_in;
  logic [3:0] bg_g_in;
  logic [3:0] bg_b_in;

  logic [3:0] vga_r_out;
  logic [3:0] vga_g_out;
  logic [3:0] vga_b_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       vga_active_out;

  // Master is the upstream side that produces timing/background and consumes final pixels.
  modport master (
    output hcount_in, vcount_in, vga_active_in, hsync_in, vsync_in,
    output bg_r_in, bg_g_in, bg_b_in,
    input  vga_r_out, vga_g_out, vga_b_out, hsync_out, vsync_out, vga_active_out
  );

  modport slave (
    input  hcount_in, vcount_in, vga_active_in, hsync_in, vsync_in,
    input  bg_r_in, bg_g_in, bg_b_in,
    output vga_r_out, vga_g_out, vga_b_out, hsync_out, vsync_out, vga_active_out
  );

endinterface

// File: rtl/vga_bounce_axis.sv
// One-axis sprite position: steps by STEP per tick and reverses, clamped, at 0 and LIMIT-SIZE.
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int STEP  = 2,
  parameter int INIT  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       en_i,
  output logic [9:0] pos_o,
  output logic       bounce_o
);

  localparam logic [10:0] LIMIT11 = 11'(LIMIT);
  localparam logic [10:0] SIZE11  = 11'(SIZE);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [9:0]  INIT10  = 10'(INIT);

  logic [9:0]  pos_q, pos_d;
  dir_t        dir_q, dir_d;
  logic        bounce_d;
  logic [10:0] pos11;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q <= INIT10;
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    pos11    = {1'b0, pos_q};
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    if (tick_i && en_i) begin
      if (dir_q == DIR_INC) begin
        // Widened to 11 bits so the overshoot test itself cannot wrap.
        if (pos11 + SIZE11 + STEP11 > LIMIT11) begin
          pos_d    = 10'(LIMIT11 - SIZE11);
          dir_d    = DIR_DEC;
          bounce_d = 1'b1;
        end else begin
          pos_d = 10'(pos11 + STEP11);
        end
      end else begin
        if (pos11 < STEP11) begin
          pos_d    = '0;
          dir_d    = DIR_INC;
          bounce_d = 1'b1;
        end else begin
          pos_d = 10'(pos11 - STEP11);
        end
      end
    end
  end

  always_comb begin
    pos_o    = pos_q;
    bounce_o = bounce_d;
  end

endmodule

// File: rtl/vga_sprite_overlay.sv
// Two-stage overlay of a bouncing solid square onto the background stream; all outputs share latency 2.
module vga_sprite_overlay
  import vga_pkg::*;
#(
  parameter int     H_ACTIVE    = H_ACTIVE_640,
  parameter int     V_ACTIVE    = V_ACTIVE_480,
  parameter int     SPRITE_SIZE = 32,
  parameter int     STEP        = 2,
  parameter int     INIT_X      = 100,
  parameter int     INIT_Y      = 60,
  parameter rgb12_t SPRITE_RGB  = 12'hF00,
  parameter logic   SYNC_IDLE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_sprite_overlay_if.slave   vid,
  input  logic                  move_en,
  output logic                  edge_hit,
  output logic [9:0]            sprite_x,
  output logic [9:0]            sprite_y
);

  typedef struct packed {
    logic   hit;
    rgb12_t bg;
    logic   active;
    logic   hsync;
    logic   vsync;
  } stage1_t;

  localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);
  localparam stage1_t S1_RST = '{hit: 1'b0, bg: '0, active: 1'b0,
                                 hsync: SYNC_IDLE, vsync: SYNC_IDLE};

  logic        tick;
  logic        bounce_x, bounce_y;
  logic        edge_hit_q;
  logic [10:0] h11, v11, x11, y11;
  stage1_t     s1_q, s1_d;
  rgb12_t      rgb_q, rgb_d;
  logic        active_q, hsync_q, vsync_q;

  // First pixel of the first blanking line: position only ever moves off-screen.
  assign tick = (vid.hcount_in == '0) && (vid.vcount_in == 10'(V_ACTIVE));

  vga_bounce_axis #(
    .LIMIT (H_ACTIVE),
    .SIZE  (SPRITE_SIZE),
    .STEP  (STEP),
    .INIT  (INIT_X)
  ) u_axis_x (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (tick),
    .en_i     (move_en),
    .pos_o    (sprite_x),
    .bounce_o (bounce_x)
  );

  vga_bounce_axis #(
    .LIMIT (V_ACTIVE),
    .SIZE  (SPRITE_SIZE),
    .STEP  (STEP),
    .INIT  (INIT_Y)
  ) u_axis_y (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (tick),
    .en_i     (move_en),
    .pos_o    (sprite_y),
    .bounce_o (bounce_y)
  );

  always_comb begin
    h11 = {1'b0, vid.hcount_in};
    v11 = {1'b0, vid.vcount_in};
    x11 = {1'b0, sprite_x};
    y11 = {1'b0, sprite_y};
    s1_d.hit    = (h11 >= x11) && (h11 < x11 + SIZE11) &&
                  (v11 >= y11) && (v11 < y11 + SIZE11);
    s1_d.bg     = '{r: vid.bg_r_in, g: vid.bg_g_in, b: vid.bg_b_in};
    s1_d.active = vid.vga_active_in;
    s1_d.hsync  = vid.hsync_in;
    s1_d.vsync  = vid.vsync_in;
  end

  // Blanking forces black, so off-screen counts can never show sprite pixels.
  always_comb begin
    rgb_d = '0;
    if (s1_q.active) rgb_d = s1_q.hit ? SPRITE_RGB : s1_q.bg;
  end

  // NOTE: every pipeline flop is reset to its idle value so no stale sync or colour leaks out after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= S1_RST;
      rgb_q      <= '0;
      active_q   <= 1'b0;
      hsync_q    <= SYNC_IDLE;
      vsync_q    <= SYNC_IDLE;
      edge_hit_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      rgb_q      <= rgb_d;
      active_q   <= s1_q.active;
      hsync_q    <= s1_q.hsync;
      vsync_q    <= s1_q.vsync;
      edge_hit_q <= bounce_x | bounce_y;
    end
  end

  assign vid.vga_r_out      = rgb_q.r;
  assign vid.vga_g_out      = rgb_q.g;
  assign vid.vga_b_out      = rgb_q.b;
  assign vid.vga_active_out = active_q;
  assign vid.hsync_out      = hsync_q;
  assign vid.vsync_out      = vsync_q;
  assign edge_hit           = edge_hit_q;

endmodule

// File: doc/vga_sprite_overlay.md
Name: vga_sprite_overlay

Overview:
- Downstream stage of vga_timing and vga_pixel_gen, sitting between the pixel generator and the VGA pins.
- Consumes hcount, vcount, vga_active, hsync and vsync from vga_timing, plus 4:4:4 background RGB from vga_pixel_gen.
- Overlays a solid square sprite that bounces off the visible-area edges, moving once per frame.
- Re-times syncs and RGB so every output has identical 2-cycle latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SPRITE_SIZE, 32, sprite edge length in pixels (1..V_ACTIVE)
- STEP, 2, pixels moved per frame per axis (1..SPRITE_SIZE)
- INIT_X, 100, reset x position (0..H_ACTIVE-SPRITE_SIZE)
- INIT_Y, 60, reset y position (0..V_ACTIVE-SPRITE_SIZE)
- SPRITE_RGB, 12'hF00, sprite colour as {r,g,b}
- SYNC_IDLE, 1'b1, reset value driven on hsync_out/vsync_out

Ports:
- clk  in  1  pixel clock (25.175 MHz)
- rst  in  1  asynchronous, active-low reset
- hcount_in  in  10  horizontal count from vga_timing
- vcount_in  in  10  vertical count from vga_timing
- vga_active_in  in  1  visible-area flag
- hsync_in  in  1  horizontal sync from vga_timing
- vsync_in  in  1  vertical sync from vga_timing
- bg_r_in, bg_g_in, bg_b_in  in  4 each  background colour, aligned with hcount_in/vcount_in
- move_en  in  1  1 = sprite moves at frame tick; 0 = frozen
- vga_r_out, vga_g_out, vga_b_out  out  4 each  final colour
- hsync_out, vsync_out  out  1  syncs delayed 2 cycles
- vga_active_out  out  1  vga_active delayed 2 cycles
- edge_hit  out  1  one-cycle pulse when any axis reverses direction
- sprite_x, sprite_y  out  10  current top-left position

Behaviour:
- Reset (rst=0, async):
  - x=INIT_X, y=INIT_Y; dir_x=right, dir_y=down.
  - RGB outputs, vga_active_out and edge_hit are 0.
  - hsync_out and vsync_out are SYNC_IDLE.
  - All pipeline registers are cleared to these same values.
- Pipeline, fixed latency 2 for every output; no bubbles.
  - Stage 1 registers hit = (x <= hcount_in < x+SIZE) && (y <= vcount_in < y+SIZE), compared at 11 bits. It also registers bg colour, active and both syncs.
  - Stage 2 output colour:
    - active=0: 0.
    - active=1 and hit=1: SPRITE_RGB.
    - otherwise: bg.
- Frame tick: a single-cycle internal pulse when hcount_in==0 && vcount_in==V_ACTIVE. Position therefore changes only in vertical blanking, so there is no tearing.
- Per-axis update on tick when move_en=1 (shown for x; y is identical with V_ACTIVE):
  - dir right and x+SIZE+STEP > H_ACTIVE: x = H_ACTIVE-SIZE, dir flips to left, bounce.
  - dir right, otherwise: x += STEP.
  - dir left and x < STEP: x = 0, dir flips to right, bounce.
  - dir left, otherwise: x -= STEP.
  - All arithmetic is 11-bit; no wrap is permitted.
- move_en=0 at tick: position and direction hold, and no edge_hit.
- edge_hit is registered and asserts in the cycle after the tick if either axis bounced. Simultaneous x and y bounce (corner) gives a single one-cycle pulse.
- sprite_x and sprite_y are the live position registers.
- Counts outside the visible area never produce visible sprite pixels, because colour is gated by active.
- Reset asserted mid-frame returns all state to reset values immediately. After release, output resumes 2 cycles after valid inputs, with no spurious edge_hit.

Decomposition:
- vga_pkg (shared):
  - Constants H_ACTIVE_640=640, V_ACTIVE_480=480, H_TOTAL=800, V_TOTAL=525.
  - typedef rgb12_t (packed struct of three 4-bit fields).
  - typedef dir_t enum {DIR_INC, DIR_DEC}.
- Sub-module vga_bounce_axis: one-axis position/direction updater. Parameters LIMIT, SIZE, STEP, INIT. Inputs tick, en. Outputs pos and bounce. Instantiated twice, for x and y.

Test Plan:
- Reset: hold rst=0 for 100 ns → RGB=0, active_out=0, syncs=1, sprite_x=100, sprite_y=60, edge_hit=0. After release with no tick, position is unchanged.
- Latency: drive hsync_in low at cycle N → hsync_out low at cycle N+2. Same check for vsync and active; bg=12'h0A5 with no hit → out=12'h0A5 at N+2.
- Overlay/blanking:
  - hcount=100, vcount=60, active=1 → out=12'hF00.
  - hcount=132 (SIZE boundary) → bg.
  - Same hit pixel with active=0 → 0.
- Right-wall bounce, INIT_X=606: after tick 1, x=608. Tick 2 → x=608, dir left, edge_hit pulses for exactly 1 cycle. Tick 3 → x=606.
- Corner: INIT_X=608, INIT_Y=448 → one tick flips both directions, exactly one edge_hit pulse, x=608, y=448. Next tick → x=606, y=446.
- move_en=0 over 3 frames → sprite_x/sprite_y constant, edge_hit stays 0. Asserting rst mid-line then restores 100/60.
